// File: rtl/store_buffer_if.sv
// store_buffer_if: pipeline store/load ports and the single-port memory bus of the store buffer
interface store_buffer_if #(parameter int WORD_SIZE = 32);
  logic                 st_valid;
  logic [WORD_SIZE-1:0] st_addr;
  logic [WORD_SIZE-1:0] st_data;
  logic                 st_stall;
  logic                 ld_en;
  logic [WORD_SIZE-1:0] ld_addr;
  logic [WORD_SIZE-1:0] ld_data;
  logic                 ld_stall;
  logic                 mem_writeEn;
  logic                 mem_readEn;
  logic [WORD_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_dataIn;
  logic [WORD_SIZE-1:0] mem_dataOut;
  logic                 empty;
  modport slave (
    input  st_valid, st_addr, st_data, ld_en, ld_addr, mem_dataOut,
    output st_stall, ld_data, ld_stall, mem_writeEn, mem_readEn, mem_address, mem_dataIn, empty
  );
  modport master (
    output st_valid, st_addr, st_data, ld_en, ld_addr, mem_dataOut,
    input  st_stall, ld_data, ld_stall, mem_writeEn, mem_readEn, mem_address, mem_dataIn, empty
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order word store queue that drains to memory when no load holds the port.
// Define STORE_BUFFER_FORWARD_EN to forward pending stores to loads; otherwise matching loads stall.
module store_buffer #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 4
) (
  input logic clk,
  input logic rst,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WORD_SIZE-1:0] addr_q [DEPTH];
  logic [WORD_SIZE-1:0] data_q [DEPTH];
  logic [AW-1:0] head, tail, idx;
  logic [AW:0] count;
  logic push, pop, hit;
`ifdef STORE_BUFFER_FORWARD_EN
  logic [WORD_SIZE-1:0] fwd;
`endif
  assign bus.empty    = count == '0;
  assign bus.st_stall = count == FULL;
  assign push = bus.st_valid && !bus.st_stall;
  assign pop  = bus.mem_writeEn;
  // scan oldest to youngest so the last hit wins as the youngest matching store
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STORE_BUFFER_FORWARD_EN
    fwd = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if ((AW+1)'(k) < count && addr_q[idx][WORD_SIZE-1:2] == bus.ld_addr[WORD_SIZE-1:2]) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FORWARD_EN
        fwd = data_q[idx];
`endif
      end
    end
  end
`ifdef STORE_BUFFER_FORWARD_EN
  assign bus.ld_stall    = 1'b0;
  assign bus.ld_data     = hit ? fwd : bus.mem_dataOut;
  assign bus.mem_readEn  = bus.ld_en;
  assign bus.mem_writeEn = !bus.empty && !bus.ld_en;
`else
  assign bus.ld_stall    = bus.ld_en && hit;
  assign bus.ld_data     = bus.mem_dataOut;
  assign bus.mem_readEn  = bus.ld_en && !hit;
  assign bus.mem_writeEn = !bus.empty && (!bus.ld_en || hit);
`endif
  assign bus.mem_address = bus.mem_readEn ? bus.ld_addr : addr_q[head];
  assign bus.mem_dataIn  = data_q[head];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= bus.st_addr;
      data_q[tail] <= bus.st_data;
    end
  end
endmodule
